// File: rtl/rx_edge_bit_timer_pkg.sv
// Shared types and limits for the oversampling RX bit timer.
package rx_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int MIN_PRESCALE   = 4;
  localparam int MIN_FRAME_BITS = 1;

endpackage

// File: rtl/rx_sample_strobe_gen.sv
// Registered bit-centre sampling strobe; the RX_EDGE_TIMER_MAJ3_EN macro selects
// three strobes around the centre (majority voting) instead of a single one.
module rx_sample_strobe_gen #(
  parameter int PRESC_W = 6
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               run_n,
  input  logic [PRESC_W-1:0] edge_n,
  input  logic [PRESC_W-1:0] presc_n,
  output logic               sample_stb
);

  logic [PRESC_W-1:0] mid;
  logic               hit;

  assign mid = presc_n >> 1;

  // Compare against the next-cycle counter so the registered strobe lines up with edge_cnt.
  always_comb begin
    hit = 1'b0;
`ifdef RX_EDGE_TIMER_MAJ3_EN
    hit = (edge_n == mid - PRESC_W'(1)) || (edge_n == mid) || (edge_n == mid + PRESC_W'(1));
`else
    hit = (edge_n == mid);
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sample_stb <= 1'b0;
    end else begin
      sample_stb <= run_n && hit;
    end
  end

endmodule

// File: rtl/rx_edge_bit_timer.sv
// Edge/bit/frame timer for UART-style RX oversampling.
// Optional macro RX_EDGE_TIMER_MAJ3_EN (in rx_sample_strobe_gen) gives 3 strobes per bit.
module rx_edge_bit_timer
  import rx_timer_pkg::*;
#(
  parameter int PRESC_W = 6,
  parameter int BIT_W   = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               enable,
  input  logic [PRESC_W-1:0] prescale,
  input  logic [BIT_W-1:0]   frame_bits,
  output logic [PRESC_W-1:0] edge_cnt,
  output logic [BIT_W-1:0]   bit_cnt,
  output logic               sample_stb,
  output logic               bit_done,
  output logic               frame_done,
  output logic               busy
);

  localparam logic [PRESC_W-1:0] PRESC_MIN = PRESC_W'(MIN_PRESCALE);
  localparam logic [BIT_W-1:0]   BITS_MIN  = BIT_W'(MIN_FRAME_BITS);

  state_t             state, state_n;
  logic [PRESC_W-1:0] presc_q, presc_n, edge_n;
  logic [BIT_W-1:0]   bits_q, bits_n, bit_n;
  logic               last_edge, last_bit, run_n;

  assign last_edge = (edge_cnt == presc_q - PRESC_W'(1));
  assign last_bit  = (bit_cnt == bits_q - BIT_W'(1));
  assign run_n     = (state_n == RUN);
  assign busy      = (state == RUN);

  always_comb begin
    state_n = state;
    presc_n = presc_q;
    bits_n  = bits_q;
    edge_n  = edge_cnt;
    bit_n   = bit_cnt;
    if (!enable) begin
      state_n = IDLE;
      edge_n  = '0;
      bit_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_n = RUN;
          presc_n = (prescale < PRESC_MIN) ? PRESC_MIN : prescale;
          bits_n  = (frame_bits < BITS_MIN) ? BITS_MIN : frame_bits;
          edge_n  = '0;
          bit_n   = '0;
        end
        RUN: begin
          if (last_edge) begin
            edge_n = '0;
            if (last_bit) begin
              bit_n   = '0;
              state_n = HOLD;
            end else begin
              bit_n = bit_cnt + BIT_W'(1);
            end
          end else begin
            edge_n = edge_cnt + PRESC_W'(1);
          end
        end
        HOLD: begin
          edge_n = '0;
          bit_n  = '0;
        end
        default: begin
          state_n = IDLE;
          edge_n  = '0;
          bit_n   = '0;
        end
      endcase
    end
  end

  // Pulses are computed from next-cycle values so they coincide with the counters they describe.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      presc_q    <= PRESC_MIN;
      bits_q     <= BITS_MIN;
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      bit_done   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      presc_q    <= presc_n;
      bits_q     <= bits_n;
      edge_cnt   <= edge_n;
      bit_cnt    <= bit_n;
      bit_done   <= run_n && (edge_n == presc_n - PRESC_W'(1));
      frame_done <= run_n && (edge_n == presc_n - PRESC_W'(1)) && (bit_n == bits_n - BIT_W'(1));
    end
  end

  rx_sample_strobe_gen #(
    .PRESC_W(PRESC_W)
  ) u_strobe (
    .CLK       (CLK),
    .RST       (RST),
    .run_n     (run_n),
    .edge_n    (edge_n),
    .presc_n   (presc_n),
    .sample_stb(sample_stb)
  );

endmodule

// File: tb/tb_rx_edge_bit_timer.sv
// Directed self-checking bench for rx_edge_bit_timer (either RX_EDGE_TIMER_MAJ3_EN build).
module tb_rx_edge_bit_timer;

  logic       CLK = 1'b0;
  logic       RST;
  logic       enable;
  logic [5:0] prescale;
  logic [3:0] frame_bits;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       sample_stb, bit_done, frame_done, busy;

  int n_checks = 0;
  int n_fail   = 0;

  rx_edge_bit_timer #(.PRESC_W(6), .BIT_W(4)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .enable    (enable),
    .prescale  (prescale),
    .frame_bits(frame_bits),
    .edge_cnt  (edge_cnt),
    .bit_cnt   (bit_cnt),
    .sample_stb(sample_stb),
    .bit_done  (bit_done),
    .frame_done(frame_done),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; enable = 1'b0; prescale = 6'd8; frame_bits = 4'd10;
    step();
    step();
    RST = 1'b0;
    n_checks++;
    if ({edge_cnt, bit_cnt, busy, bit_done, frame_done, sample_stb} !== 14'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_state: got edge=%0d bit=%0d busy=%b bd=%b fd=%b stb=%b, expected all 0",
               edge_cnt, bit_cnt, busy, bit_done, frame_done, sample_stb);
    end
    step();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL idle_no_enable: busy=%b expected 0", busy);
    end
  endtask

  // Runs one whole frame from IDLE, checking every RUN cycle against a reference count,
  // then HOLD behaviour and the return to IDLE. Inputs are scrambled mid-frame to prove capture.
  task automatic test_full_frame(input logic [5:0] p, input logic [3:0] fb);
    int pe, be, mid, total, exp_edge, exp_bit, nbd, nfd, nstb, exp_nstb;
    logic exp_stb, exp_bd, exp_fd;
    pe = (p < 4) ? 4 : int'(p);
    be = (fb == 0) ? 1 : int'(fb);
    mid = pe / 2;
    total = pe * be;
    nbd = 0; nfd = 0; nstb = 0;
    prescale = p; frame_bits = fb; enable = 1'b1;
    for (int k = 1; k <= total; k++) begin
      step();
      if (k == 2) begin
        prescale = ~p;
        frame_bits = 4'd15;
      end
      exp_edge = (k - 1) % pe;
      exp_bit  = (k - 1) / pe;
      exp_bd   = (exp_edge == pe - 1);
      exp_fd   = (k == total);
`ifdef RX_EDGE_TIMER_MAJ3_EN
      exp_stb = (exp_edge >= mid - 1) && (exp_edge <= mid + 1);
`else
      exp_stb = (exp_edge == mid);
`endif
      if (bit_done) nbd++;
      if (frame_done) nfd++;
      if (sample_stb) nstb++;
      n_checks++;
      if (edge_cnt !== 6'(exp_edge) || bit_cnt !== 4'(exp_bit) || busy !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL frame_counters p=%0d fb=%0d k=%0d: got edge=%0d bit=%0d busy=%b, expected edge=%0d bit=%0d busy=1",
                 p, fb, k, edge_cnt, bit_cnt, busy, exp_edge, exp_bit);
      end
      n_checks++;
      if (bit_done !== exp_bd || frame_done !== exp_fd || sample_stb !== exp_stb) begin
        n_fail++;
        $display("[TB] FAIL frame_pulses p=%0d fb=%0d k=%0d: got bd=%b fd=%b stb=%b, expected bd=%b fd=%b stb=%b",
                 p, fb, k, bit_done, frame_done, sample_stb, exp_bd, exp_fd, exp_stb);
      end
    end
`ifdef RX_EDGE_TIMER_MAJ3_EN
    exp_nstb = 3 * be;
`else
    exp_nstb = be;
`endif
    n_checks++;
    if (nbd != be || nfd != 1 || nstb != exp_nstb) begin
      n_fail++;
      $display("[TB] FAIL frame_totals p=%0d fb=%0d: got bd=%0d fd=%0d stb=%0d, expected bd=%0d fd=1 stb=%0d",
               p, fb, nbd, nfd, nstb, be, exp_nstb);
    end
    for (int h = 0; h < 3; h++) begin
      step();
      n_checks++;
      if ({edge_cnt, bit_cnt, busy, bit_done, frame_done, sample_stb} !== 14'd0) begin
        n_fail++;
        $display("[TB] FAIL hold_state h=%0d: got edge=%0d bit=%0d busy=%b bd=%b fd=%b stb=%b, expected all 0",
                 h, edge_cnt, bit_cnt, busy, bit_done, frame_done, sample_stb);
      end
    end
    enable = 1'b0;
    step();
    n_checks++;
    if (busy !== 1'b0 || edge_cnt !== 6'd0) begin
      n_fail++;
      $display("[TB] FAIL hold_exit: got busy=%b edge=%0d, expected busy=0 edge=0", busy, edge_cnt);
    end
  endtask

  task automatic test_abort();
    prescale = 6'd8; frame_bits = 4'd10; enable = 1'b1;
    for (int k = 1; k <= 44; k++) step();
    n_checks++;
    if (edge_cnt !== 6'd3 || bit_cnt !== 4'd5) begin
      n_fail++;
      $display("[TB] FAIL abort_position: got edge=%0d bit=%0d, expected edge=3 bit=5", edge_cnt, bit_cnt);
    end
    enable = 1'b0;
    step();
    n_checks++;
    if ({edge_cnt, bit_cnt, busy, bit_done, frame_done, sample_stb} !== 14'd0) begin
      n_fail++;
      $display("[TB] FAIL abort_clear: got edge=%0d bit=%0d busy=%b bd=%b fd=%b stb=%b, expected all 0",
               edge_cnt, bit_cnt, busy, bit_done, frame_done, sample_stb);
    end
    step();
    n_checks++;
    if (frame_done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL abort_idle: got fd=%b busy=%b, expected fd=0 busy=0", frame_done, busy);
    end
    enable = 1'b1;
    step();
    n_checks++;
    if (edge_cnt !== 6'd0 || bit_cnt !== 4'd0 || busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL abort_restart: got edge=%0d bit=%0d busy=%b, expected edge=0 bit=0 busy=1",
               edge_cnt, bit_cnt, busy);
    end
    for (int k = 2; k <= 9; k++) step();
    n_checks++;
    if (edge_cnt !== 6'd0 || bit_cnt !== 4'd1) begin
      n_fail++;
      $display("[TB] FAIL abort_restart_bit1: got edge=%0d bit=%0d, expected edge=0 bit=1", edge_cnt, bit_cnt);
    end
    enable = 1'b0;
    step();
  endtask

  task automatic test_prescale_change();
    prescale = 6'd8; frame_bits = 4'd2; enable = 1'b1;
    step();
    prescale = 6'd16;
    for (int k = 2; k <= 8; k++) step();
    n_checks++;
    if (bit_done !== 1'b1 || edge_cnt !== 6'd7 || frame_done !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL presc_keep_bit0: got bd=%b edge=%0d fd=%b, expected bd=1 edge=7 fd=0",
               bit_done, edge_cnt, frame_done);
    end
    for (int k = 9; k <= 16; k++) step();
    n_checks++;
    if (frame_done !== 1'b1 || edge_cnt !== 6'd7 || bit_cnt !== 4'd1) begin
      n_fail++;
      $display("[TB] FAIL presc_keep_frame: got fd=%b edge=%0d bit=%0d, expected fd=1 edge=7 bit=1",
               frame_done, edge_cnt, bit_cnt);
    end
    step();
    enable = 1'b0;
    step();
    enable = 1'b1;
    for (int k = 1; k <= 16; k++) step();
    n_checks++;
    if (edge_cnt !== 6'd15 || bit_done !== 1'b1 || bit_cnt !== 4'd0 || frame_done !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL presc_new_frame: got edge=%0d bd=%b bit=%0d fd=%b, expected edge=15 bd=1 bit=0 fd=0",
               edge_cnt, bit_done, bit_cnt, frame_done);
    end
    step();
    n_checks++;
    if (edge_cnt !== 6'd0 || bit_cnt !== 4'd1) begin
      n_fail++;
      $display("[TB] FAIL presc_new_bit1: got edge=%0d bit=%0d, expected edge=0 bit=1", edge_cnt, bit_cnt);
    end
    enable = 1'b0;
    step();
  endtask

  task automatic test_reset_midframe();
    prescale = 6'd8; frame_bits = 4'd10; enable = 1'b1;
    for (int k = 1; k <= 20; k++) step();
    RST = 1'b1;
    step();
    n_checks++;
    if ({edge_cnt, bit_cnt, busy, bit_done, frame_done, sample_stb} !== 14'd0) begin
      n_fail++;
      $display("[TB] FAIL midframe_reset: got edge=%0d bit=%0d busy=%b bd=%b fd=%b stb=%b, expected all 0",
               edge_cnt, bit_cnt, busy, bit_done, frame_done, sample_stb);
    end
    RST = 1'b0;
    step();
    n_checks++;
    if (busy !== 1'b1 || edge_cnt !== 6'd0 || bit_cnt !== 4'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_then_start: got busy=%b edge=%0d bit=%0d, expected busy=1 edge=0 bit=0",
               busy, edge_cnt, bit_cnt);
    end
    enable = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_full_frame(6'd8, 4'd10);
    test_full_frame(6'd2, 4'd3);
    test_full_frame(6'd6, 4'd0);
    test_abort();
    test_prescale_change();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
